uart_word_rx: RTL and testbench
===============================

# uart_word_rx

UART receive-side deserializer that feeds the `memory_com` read path. When armed by a read request, it samples the `rx` line and decodes 8N1 frames. It assembles 1, 2 or 4 bytes little-endian into a 32-bit word, then hands the word over with a one-cycle valid pulse. It reports framing errors and reports a missing response via an idle timeout.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 434: clock cycles per UART bit (50 MHz / 115200). Must be ≥ 4.
- `TIMEOUT_CLKS`, default 8680: maximum idle clocks allowed while waiting for any start bit.

Ports:
- `clk`, in, 1: single system clock.
- `reset`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: raw UART line, idle high, asynchronous to `clk`.
- `start`, in, 1: one-cycle arm request from `memory_com`. Ignored while `busy`=1.
- `num_bytes`, in, 3: bytes to receive, captured on `start`. Legal values 1, 2, 4; any other value is treated as 4.
- `word`, out, 32: assembled word. Byte k is placed at bits [8k+7:8k]; bytes not received read as 0.
- `word_valid`, out, 1: one-cycle pulse; `word` is complete.
- `busy`, out, 1: a transaction is armed or in progress.
- `frame_err`, out, 1: one-cycle pulse; a stop bit was sampled as 0.
- `timeout`, out, 1: one-cycle pulse; no start bit arrived within `TIMEOUT_CLKS`.

## Operation
- Input conditioning: `rx` passes through a 2-flop synchronizer. All references to `rx` below mean the synchronized value.
- FSM states: IDLE, WAIT_START, START, DATA, STOP.
- IDLE:
  - On `start`, latch the byte target, clear `word` and the byte counter, set `busy`, and go to WAIT_START.
  - `start` has no effect in any other state.
- WAIT_START:
  - A falling edge of `rx` (1→0) goes to START and clears the bit timer.
  - The idle counter increments every cycle. At `TIMEOUT_CLKS` it pulses `timeout`, clears `busy`, and returns to IDLE.
  - The idle counter reloads on each entry to WAIT_START, so the timeout applies per byte.
- START:
  - At bit timer = `CLKS_PER_BIT/2` (integer division), sample `rx`.
  - If the sample is 0, go to DATA.
  - If the sample is 1 (glitch), return to WAIT_START. The idle counter is not reset by a glitch.
- DATA: sample 8 bits LSB first, each `CLKS_PER_BIT` clocks after the previous sample.
- STOP:
  - Sample one bit `CLKS_PER_BIT` after the last data bit.
  - Sample = 1: store the byte in slot [byte count] and increment the count.
    - If the count now equals the target, pulse `word_valid`, clear `busy`, and go to IDLE.
    - Otherwise return to WAIT_START.
  - Sample = 0: pulse `frame_err`, clear `busy`, and go to IDLE. `word_valid` is not asserted, and `word` keeps its partial contents.
- `word` holds its value until the next accepted `start`.
- Reset (asynchronous, active-low): state IDLE, `word`=0, all pulses and `busy`=0, counters=0, synchronizer flops=1.
- Reset asserted mid-frame aborts the transaction with no pulse.

## Timing
- Let T be the first clock where synchronized `rx`=0 after a high value; T is 2–3 clocks after the pin edge.
- Sample instants relative to T:
  - Start check: T+`CLKS_PER_BIT/2`.
  - Data bit i (0..7): T+`CLKS_PER_BIT/2`+(i+1)·`CLKS_PER_BIT`.
  - Stop bit: T+`CLKS_PER_BIT/2`+9·`CLKS_PER_BIT`.
- `word_valid`, `frame_err` and `timeout` are registered. Each is high for exactly the one cycle after the deciding sample.
- `busy` falls in that same cycle.
- At most one of `word_valid`, `frame_err` and `timeout` is high in any cycle.
- `busy` rises the cycle after `start`. A `start` in the same cycle `busy` falls is ignored; the earliest accepted re-arm is the following cycle.
- Back-to-back frames are accepted because the stop sample occurs mid-bit, leaving half a bit of margin before the next start edge.

## Test plan
All scenarios use `CLKS_PER_BIT`=16 and `TIMEOUT_CLKS`=400.
- Reset: drive `reset`=0 while toggling `rx`. Required: `word`=0 and `busy`=`word_valid`=`frame_err`=`timeout`=0. After release, `busy` stays 0 without `start`.
- 4-byte read: `start` with `num_bytes`=4, then frames 0x78, 0x56, 0x34, 0x12 back-to-back. Required: exactly one `word_valid` pulse, `word`=0x12345678, and the pulse lands 16·9+8 clocks (±1) after the last frame's start edge.
- 1-byte and illegal size:
  - `num_bytes`=1 with frame 0xA5. Required: `word`=0x000000A5.
  - `num_bytes`=3 with 4 frames 0x01..0x04. Required: `word`=0x04030201.
- Framing error: `num_bytes`=2; frame 0x11, then frame 0x22 with its stop bit held 0. Required: one `frame_err` pulse, no `word_valid`, `busy`=0, `word`=0x00000011.
- Glitch then timeout: `start`, then a 4-clock low pulse on `rx`, then idle. Required: no `word_valid`, and `timeout` pulses 400 clocks (±1) after the WAIT_START entry.
- Reset mid-frame: assert `reset` during data bit 3 of the first byte. Required: all outputs 0 immediately. A subsequent `start` plus frame 0x5A with `num_bytes`=1 yields `word`=0x0000005A.

Source files
------------

// File: rtl/uart_word_rx.sv
// UART 8N1 receive deserializer: assembles 1, 2 or 4 bytes little-endian into a
// 32-bit word, with framing-error and per-byte idle-timeout reporting.
module uart_word_rx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_CLKS = 8680
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rx,
    input  logic        start,
    input  logic [2:0]  num_bytes,
    output logic [31:0] word,
    output logic        word_valid,
    output logic        busy,
    output logic        frame_err,
    output logic        timeout
);

    localparam int TW = $clog2(CLKS_PER_BIT + 1);
    // Idle counter keeps running through START, so it may overshoot the limit by half a bit.
    localparam int IW = $clog2(TIMEOUT_CLKS + CLKS_PER_BIT + 1);
    localparam logic [TW-1:0] HALF_BIT   = TW'(CLKS_PER_BIT / 2);
    localparam logic [TW-1:0] FULL_BIT   = TW'(CLKS_PER_BIT);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_CLKS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_START,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t        state_q, state_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [TW-1:0] timer_q, timer_d;
    logic [IW-1:0] idle_q, idle_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic [2:0]    byte_cnt_q, byte_cnt_d;
    logic [2:0]    target_q, target_d;
    logic [7:0]    shift_q, shift_d;
    logic [31:0]   word_q, word_d;
    logic          busy_q, busy_d;
    logic          word_valid_q, word_valid_d;
    logic          frame_err_q, frame_err_d;
    logic          timeout_q, timeout_d;

    logic rx_fall;
    logic ending_cycle;

    assign rx_fall = rx_prev_q & ~rx_sync_q;
    // busy has just dropped this cycle; a start here must not re-arm.
    assign ending_cycle = word_valid_q | frame_err_q | timeout_q;

    always_comb begin
        state_d      = state_q;
        timer_d      = timer_q;
        idle_d       = idle_q;
        bit_cnt_d    = bit_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        target_d     = target_q;
        shift_d      = shift_q;
        word_d       = word_q;
        busy_d       = busy_q;
        word_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        timeout_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start && !ending_cycle) begin
                    target_d   = (num_bytes == 3'd1 || num_bytes == 3'd2) ? num_bytes : 3'd4;
                    word_d     = '0;
                    byte_cnt_d = '0;
                    idle_d     = '0;
                    busy_d     = 1'b1;
                    state_d    = S_WAIT_START;
                end
            end
            S_WAIT_START: begin
                idle_d = idle_q + IW'(1);
                if (idle_q >= IDLE_LIMIT) begin
                    timeout_d = 1'b1;
                    busy_d    = 1'b0;
                    state_d   = S_IDLE;
                end else if (rx_fall) begin
                    timer_d = TW'(1);
                    state_d = S_START;
                end
            end
            S_START: begin
                // Timer counts clocks since the edge, so the check lands mid start bit.
                idle_d  = idle_q + IW'(1);
                timer_d = timer_q + TW'(1);
                if (timer_q == HALF_BIT) begin
                    if (!rx_sync_q) begin
                        timer_d   = TW'(1);
                        bit_cnt_d = '0;
                        state_d   = S_DATA;
                    end else begin
                        state_d = S_WAIT_START;
                    end
                end
            end
            S_DATA: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == FULL_BIT) begin
                    shift_d   = {rx_sync_q, shift_q[7:1]};
                    timer_d   = TW'(1);
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = S_STOP;
                    end
                end
            end
            S_STOP: begin
                timer_d = timer_q + TW'(1);
                if (timer_q == FULL_BIT) begin
                    if (rx_sync_q) begin
                        word_d[{byte_cnt_q[1:0], 3'b000} +: 8] = shift_q;
                        byte_cnt_d = byte_cnt_q + 3'd1;
                        if (byte_cnt_q + 3'd1 == target_q) begin
                            word_valid_d = 1'b1;
                            busy_d       = 1'b0;
                            state_d      = S_IDLE;
                        end else begin
                            idle_d  = '0;
                            state_d = S_WAIT_START;
                        end
                    end else begin
                        frame_err_d = 1'b1;
                        busy_d      = 1'b0;
                        state_d     = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            rx_meta_q    <= 1'b1;
            rx_sync_q    <= 1'b1;
            rx_prev_q    <= 1'b1;
            timer_q      <= '0;
            idle_q       <= '0;
            bit_cnt_q    <= '0;
            byte_cnt_q   <= '0;
            target_q     <= '0;
            shift_q      <= '0;
            word_q       <= '0;
            busy_q       <= 1'b0;
            word_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            timeout_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            rx_meta_q    <= rx;
            rx_sync_q    <= rx_meta_q;
            rx_prev_q    <= rx_sync_q;
            timer_q      <= timer_d;
            idle_q       <= idle_d;
            bit_cnt_q    <= bit_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            target_q     <= target_d;
            shift_q      <= shift_d;
            word_q       <= word_d;
            busy_q       <= busy_d;
            word_valid_q <= word_valid_d;
            frame_err_q  <= frame_err_d;
            timeout_q    <= timeout_d;
        end
    end

    assign word       = word_q;
    assign word_valid = word_valid_q;
    assign busy       = busy_q;
    assign frame_err  = frame_err_q;
    assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_word_rx.sv
// Self-checking bench for uart_word_rx: vector table, hand-written corner
// sequences and randomized transactions against a byte-level reference model.
module tb_uart_word_rx;

    localparam int CPB = 16;
    localparam int TO  = 400;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  num_bytes = 3'd0;
    logic [31:0] word;
    logic        word_valid, busy, frame_err, timeout;

    always #5 clk = ~clk;

    uart_word_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_CLKS(TO)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx         (rx),
        .start      (start),
        .num_bytes  (num_bytes),
        .word       (word),
        .word_valid (word_valid),
        .busy       (busy),
        .frame_err  (frame_err),
        .timeout    (timeout)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the falling edge.
    int wv_cnt = 0, fe_cnt = 0, to_cnt = 0, excl_bad = 0;
    int last_wv_cyc = 0, last_to_cyc = 0;
    always @(negedge clk) begin
        if (word_valid) begin
            wv_cnt      <= wv_cnt + 1;
            last_wv_cyc <= cyc;
        end
        if (frame_err) fe_cnt <= fe_cnt + 1;
        if (timeout) begin
            to_cnt      <= to_cnt + 1;
            last_to_cyc <= cyc;
        end
        if (int'(word_valid) + int'(frame_err) + int'(timeout) > 1) excl_bad <= excl_bad + 1;
    end

    int n_cmp = 0;
    int n_err = 0;
    int last_edge = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    task automatic check_rng(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
        end else begin
            $display("ok   %s: %0d", name, act);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        tick(CPB);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        last_edge = cyc;
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit(stop_bit);
        rx = 1'b1;
    endtask

    task automatic arm(input logic [2:0] nb);
        num_bytes = nb;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        check("busy_rise", {31'b0, busy}, 32'd1);
    endtask

    typedef struct {
        logic [2:0]  nb;
        int          nf;
        logic [31:0] data;
        int          bad;
        logic [31:0] exp_word;
        int          exp_wv;
        int          exp_fe;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int w0, f0, t0, entry;
        logic [7:0]  rb[4];
        logic [31:0] exp_word;
        int          exp_wv, exp_fe, target, bad;
        logic [2:0]  nb;

        vecs[0] = '{nb: 3'd4, nf: 4, data: 32'h12345678, bad: -1, exp_word: 32'h12345678, exp_wv: 1, exp_fe: 0};
        vecs[1] = '{nb: 3'd1, nf: 1, data: 32'h000000A5, bad: -1, exp_word: 32'h000000A5, exp_wv: 1, exp_fe: 0};
        vecs[2] = '{nb: 3'd3, nf: 4, data: 32'h04030201, bad: -1, exp_word: 32'h04030201, exp_wv: 1, exp_fe: 0};
        vecs[3] = '{nb: 3'd2, nf: 2, data: 32'h00002211, bad: 1,  exp_word: 32'h00000011, exp_wv: 0, exp_fe: 1};
        vecs[4] = '{nb: 3'd0, nf: 4, data: 32'hDEADBEEF, bad: -1, exp_word: 32'hDEADBEEF, exp_wv: 1, exp_fe: 0};
        vecs[5] = '{nb: 3'd2, nf: 2, data: 32'h0000C33C, bad: -1, exp_word: 32'h0000C33C, exp_wv: 1, exp_fe: 0};

        // Reset held while the line toggles.
        for (int i = 0; i < 10; i++) begin
            rx = ~rx;
            tick(1);
        end
        check("rst_word", word, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_word_valid", {31'b0, word_valid}, 32'd0);
        check("rst_frame_err", {31'b0, frame_err}, 32'd0);
        check("rst_timeout", {31'b0, timeout}, 32'd0);
        rx = 1'b1;
        reset = 1'b1;
        tick(30);
        check("idle_busy_no_start", {31'b0, busy}, 32'd0);

        // Vector table.
        for (int v = 0; v < 6; v++) begin
            w0 = wv_cnt;
            f0 = fe_cnt;
            tick(3);
            arm(vecs[v].nb);
            for (int j = 0; j < vecs[v].nf; j++)
                send_frame(vecs[v].data[8*j +: 8], (j != vecs[v].bad));
            tick(3);
            check($sformatf("vec%0d_word", v), word, vecs[v].exp_word);
            check($sformatf("vec%0d_valid_pulses", v), wv_cnt - w0, vecs[v].exp_wv);
            check($sformatf("vec%0d_frame_err_pulses", v), fe_cnt - f0, vecs[v].exp_fe);
            check($sformatf("vec%0d_busy_end", v), {31'b0, busy}, 32'd0);
            // Pin edge -> synchronized edge is 2..3 clocks; pulse is 152 (+-1) after that.
            if (v == 0) check_rng("vec0_valid_latency", last_wv_cyc - last_edge, 153, 157);
        end

        // Glitch on the line, then silence until the idle timeout.
        tick(3);
        w0 = wv_cnt;
        t0 = to_cnt;
        entry = cyc + 1;
        arm(3'd4);
        tick(20);
        rx = 1'b0;
        tick(4);
        rx = 1'b1;
        for (int i = 0; i < 600 && to_cnt == t0; i++) tick(1);
        check("glitch_timeout_pulses", to_cnt - t0, 1);
        check_rng("glitch_timeout_latency", last_to_cyc - entry, 399, 401);
        check("glitch_no_valid", wv_cnt - w0, 0);
        check("glitch_busy_end", {31'b0, busy}, 32'd0);

        // Reset during data bit 3 of the first byte.
        tick(3);
        arm(3'd1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b0);
        rx = 1'b1;
        tick(5);
        #2 reset = 1'b0;
        #1;
        check("midrst_word", word, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_pulses", {29'b0, word_valid, frame_err, timeout}, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(5);
        w0 = wv_cnt;
        arm(3'd1);
        send_frame(8'h5A, 1'b1);
        tick(3);
        check("midrst_rearm_word", word, 32'h0000005A);
        check("midrst_rearm_valid", wv_cnt - w0, 1);

        // Randomized transactions against a byte-level model.
        for (int t = 0; t < 10; t++) begin
            nb = 3'($urandom_range(0, 7));
            target = (nb == 3'd1 || nb == 3'd2) ? int'(nb) : 4;
            for (int i = 0; i < 4; i++) rb[i] = 8'($urandom_range(0, 255));
            bad = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, target - 1)) : -1;
            exp_word = 32'h0;
            exp_wv = 1;
            exp_fe = 0;
            for (int i = 0; i < target; i++) begin
                if (i == bad) begin
                    exp_wv = 0;
                    exp_fe = 1;
                    break;
                end
                exp_word = exp_word | (32'(rb[i]) << (8 * i));
            end
            w0 = wv_cnt;
            f0 = fe_cnt;
            tick(3);
            arm(nb);
            for (int i = 0; i < target; i++) begin
                if (i > 0) tick($urandom_range(0, 20));
                send_frame(rb[i], (i != bad));
                if (i == bad) break;
            end
            tick(3);
            check($sformatf("rnd%0d_nb%0d_word", t, nb), word, exp_word);
            check($sformatf("rnd%0d_valid_pulses", t), wv_cnt - w0, exp_wv);
            check($sformatf("rnd%0d_frame_err_pulses", t), fe_cnt - f0, exp_fe);
            check($sformatf("rnd%0d_busy_end", t), {31'b0, busy}, 32'd0);
        end

        tick(2);
        check("pulse_exclusive", excl_bad, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
